router_rr_arbiter: RTL and testbench

// Packet-level round-robin arbiter that shares one router output port (its FIFO push path) among N input ports.

---
 rtl/router_rr_arbiter.sv | 100 ++++++++++
 tb/tb_router_rr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/router_rr_arbiter.sv
// Packet-level round-robin arbiter for one router output port.
// A grant is locked for a whole frame and released on abort, on the last beat or by the hold watchdog.
module router_rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic                 blk,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy,
    output logic                 timeout,
    output logic [0:0]           fsm_state
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [IW-1:0] next_ptr;
    logic          cur_req;
    logic          cur_last;
    logic          wd_hit;
    logic          release_now;
    int            cand;

    assign fsm_state = state;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    assign cur_req     = req[grant_idx];
    assign cur_last    = last[grant_idx];
    assign wd_hit      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = !cur_req || cur_last || wd_hit;
    assign next_ptr    = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found && !blk) begin
                        state     <= S_LOCK;
                        grant     <= ONE_HOT0 << win_idx;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                S_LOCK: begin
                    if (release_now) begin
                        state     <= S_IDLE;
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                        ptr       <= next_ptr;
                        // Abort and last beat take priority over the watchdog.
                        timeout   <= cur_req && !cur_last && wd_hit;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_rr_arbiter.sv
// Self-checking bench for router_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a frame-level reference model.
module tb_router_rr_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] last  = '0;
  logic         blk   = 1'b0;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         busy;
  logic         timeout;
  logic [0:0]   fsm_state;

  router_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .blk       (blk),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout),
    .fsm_state (fsm_state)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_lock  = 1'b0;
  int m_w     = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: who owns the port, how long it has held it, where priority starts.
  task automatic model_step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] l, input bit b);
    m_tmo = 1'b0;
    if (rst) begin
      m_lock = 1'b0; m_w = 0; m_ptr = 0; m_held = 0;
    end else if (!m_lock) begin
      if (r != 0 && !b) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_w = (m_ptr + k) % N;
            break;
          end
        end
        m_lock = 1'b1;
        m_held = 1;
      end
    end else begin
      if (!r[m_w] || l[m_w] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
        m_tmo  = r[m_w] && !l[m_w];
        m_lock = 1'b0;
        m_ptr  = (m_w + 1) % N;
      end else begin
        m_held++;
      end
    end
    exp_q.push_back(m_lock ? (N'(1) << m_w) : N'(0));
  endtask

  // driver: apply inputs, advance one edge, compare against the model
  task automatic step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] l, input bit b);
    logic [N-1:0] eg;
    reset = rst; req = r; last = l; blk = b;
    model_step(rst, r, l, b);
    @(posedge clock);
    #1;
    eg = exp_q.pop_front();
    check("grant", 32'(grant), 32'(eg));
    check("grant_idx", 32'(grant_idx), m_lock ? 32'(m_w) : 32'd0);
    check("busy", 32'(busy), 32'(m_lock));
    check("timeout", 32'(timeout), 32'(m_tmo));
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    int ex;

    // 1. reset, then idle
    step(1, '0, '0, 0);
    step(1, '0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 0);

    // 2. single requester, last on 4th locked cycle
    step(0, 8'h01, '0, 0);
    check("t2_grant", 32'(grant), 32'h01);
    for (int i = 0; i < 3; i++) step(0, 8'h01, '0, 0);
    step(0, 8'h01, 8'h01, 0);
    check("t2_release", 32'(grant), 32'h00);
    step(0, '0, '0, 0);

    // 3. all requesting, 3-beat frames; priority now starts at port 1
    for (int g = 0; g < 9; g++) begin
      step(0, 8'hFF, '0, 0);
      check("t3_order", 32'(grant_idx), 32'((1 + g) % N));
      step(0, 8'hFF, '0, 0);
      step(0, 8'hFF, 8'hFF, 0);
      check("t3_gap", 32'(grant), 32'h00);
    end
    step(0, '0, '0, 0);

    // 4. move ptr to 7 by serving port 6, then wrap-around
    step(0, 8'h40, '0, 0);
    step(0, 8'h00, '0, 0);
    step(0, 8'h81, '0, 0);
    check("t4_first", 32'(grant), 32'h80);
    step(0, 8'h81, 8'h80, 0);
    step(0, 8'h81, '0, 0);
    check("t4_wrap", 32'(grant), 32'h01);
    step(0, 8'h00, '0, 0);

    // 5. blk inhibits only new grants
    for (int i = 0; i < 3; i++) step(0, 8'h10, '0, 1);
    check("t5_blocked", 32'(grant), 32'h00);
    step(0, 8'h10, '0, 0);
    check("t5_grant", 32'(grant), 32'h10);
    step(0, 8'h10, '0, 1);
    step(0, 8'h10, '0, 1);
    check("t5_held", 32'(grant), 32'h10);
    step(0, 8'h10, 8'h10, 1);
    step(0, '0, '0, 0);

    // 6. watchdog release, then reset mid-LOCK
    step(0, 8'h04, '0, 0);
    check("t6_grant", 32'(grant), 32'h04);
    for (int i = 0; i < 3; i++) step(0, 8'h04, '0, 0);
    check("t6_still", 32'(grant), 32'h04);
    step(0, 8'h04, '0, 0);
    check("t6_timeout", 32'(timeout), 32'd1);
    check("t6_dropped", 32'(grant), 32'h00);
    step(0, 8'h04, '0, 0);
    check("t6_pulse", 32'(timeout), 32'd0);
    step(0, 8'h04, '0, 0);
    step(1, 8'h04, '0, 0);
    check("t6_reset", 32'(grant), 32'h00);
    step(0, 8'hFF, '0, 0);
    check("t6_ptr0", 32'(grant), 32'h01);
    step(0, '0, '0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      l = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(($urandom_range(0, 99) == 0), r, l, ($urandom_range(0, 4) == 0));
    end

    ex = exp_q.size();
    check("queue_empty", 32'(ex), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
